// File: rtl/ram_dp_param.sv
// ram_dp_param: simple dual-port RAM with byte enables, collision mode, optional output register and self-clearing init
module ram_dp_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 64,
    parameter bit                RD_MODE  = 1'b0,
    parameter bit                OUT_REG  = 1'b0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    output logic                init_done,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid
);
    localparam int NB = DATA_W / 8;
    typedef enum logic {S_INIT, S_READY} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_d1;
    logic              r_v1;
    logic              w_act;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_word;
    assign w_act     = (r_state == S_READY) && !clear;
    assign w_wr_ok   = w_act && wr_en && (int'(wr_addr) < DEPTH);
    assign w_rd_ok   = int'(rd_addr) < DEPTH;
    assign w_old     = w_rd_ok ? r_mem[rd_addr] : '0;
    assign w_rd_word = (RD_MODE && wr_en && w_rd_ok && rd_addr == wr_addr) ? w_merged : w_old;
    assign init_done = r_init_done;
    // Word as it will look after this cycle's byte-masked write, for write-first reads
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++)
            if (wr_be[i]) w_merged[8*i +: 8] = data_in[8*i +: 8];
    end
    // Array write: the init sweep owns the array until READY, then byte-masked user writes
    always_ff @(posedge clk) begin
        if (r_state == S_INIT)
            r_mem[r_cnt] <= INIT_VAL;
        else if (w_wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) r_mem[wr_addr][8*i +: 8] <= data_in[8*i +: 8];
    end
    // Init sequencer: one pass over the array after reset or clear, counter stops at DEPTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == S_INIT) begin
            if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (clear) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end
    end
    // First read stage: data holds when idle, valid drops on clear or during init
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_act && rd_en;
            if (w_act && rd_en) r_d1 <= w_rd_word;
        end
    end
    generate
        if (OUT_REG) begin : g_oreg
            logic [DATA_W-1:0] r_d2;
            logic              r_v2;
            // Second read stage: follows stage one, flushed by an accepted clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1 && !(r_state == S_READY && clear);
                    if (r_v1 && !(r_state == S_READY && clear)) r_d2 <= r_d1;
                end
            end
            assign data_out = r_d2;
            assign rd_valid = r_v2;
        end else begin : g_noreg
            assign data_out = r_d1;
            assign rd_valid = r_v1;
        end
    endgenerate
endmodule
